laser_interlock_seq: RTL and testbench

//  Laser enable/shutdown sequencer, directly downstream of limit_check; runs on clk_div2.

---
 rtl/laser_interlock_seq.sv | 147 ++++++++++++++
 tb/tb_laser_interlock_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_interlock_seq.sv
// Laser enable/shutdown sequencer: debounces pwr_good, powers the rail, then releases the TA.
// Any unmasked limit failure or power loss latches FAULT until a qualified clear_fail edge.
module laser_interlock_seq #(
  parameter int CNT_W           = 24,
  parameter int PG_DEBOUNCE_CYC = 25000,
  parameter int ARM_DELAY_CYC   = 250000,
  parameter int FAULT_HOLD_CYC  = 2500000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       laser_ready,
  input  logic       pwr_good,
  input  logic       enable_req,
  input  logic       clear_fail,
  input  logic [3:0] fail_in,
  input  logic [3:0] fail_mask,
  output logic       laser_pwr_en,
  output logic       ta_shutdown,
  output logic [2:0] seq_state,
  output logic [4:0] fault_cause,
  output logic [7:0] fault_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PG_WAIT = 3'd1;
  localparam logic [2:0] S_ARMING  = 3'd2;
  localparam logic [2:0] S_ACTIVE  = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;

  localparam logic [CNT_W-1:0] PG_LAST  = CNT_W'(PG_DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(FAULT_HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             pg_meta, pg_s;
  logic             clear_d, clear_edge;
  logic [3:0]       fail_vec;
  logic             fail_u, run_ok;
  logic             ta_reg, ta_d, pwr_en_reg, pwr_en_d;
  logic             enter_fault, pg_loss_now;

  assign fail_vec    = fail_in & ~fail_mask;
  assign fail_u      = |fail_vec;
  assign run_ok      = enable_req & laser_ready;
  assign clear_edge  = clear_fail & ~clear_d;
  assign enter_fault = (next_state == S_FAULT) && (state != S_FAULT);
  assign pg_loss_now = ~pg_s && ((state == S_ARMING) || (state == S_ACTIVE));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pg_meta <= 1'b0;
      pg_s    <= 1'b0;
      clear_d <= 1'b0;
    end else begin
      pg_meta <= pwr_good;
      pg_s    <= pg_meta;
      clear_d <= clear_fail;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; the if-chains encode exit priority fail > pg loss > graceful stop
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (fail_u)      next_state = S_FAULT;
        else if (run_ok) next_state = S_PG_WAIT;
      end
      S_PG_WAIT: begin
        if (fail_u)                      next_state = S_FAULT;
        else if (!run_ok)                next_state = S_IDLE;
        else if (pg_s && cnt == PG_LAST) next_state = S_ARMING;
      end
      S_ARMING: begin
        if (fail_u || !pg_s)     next_state = S_FAULT;
        else if (!run_ok)        next_state = S_IDLE;
        else if (cnt == ARM_LAST) next_state = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (fail_u || !pg_s) next_state = S_FAULT;
        else if (!run_ok)    next_state = S_IDLE;
      end
      S_FAULT: begin
        if (clear_edge && cnt == HOLD_MAX && !fail_u) next_state = S_IDLE;
      end
      default: next_state = S_FAULT;
    endcase
  end

  // Every state change restarts the shared counter, so each phase times itself from zero
  always_comb begin
    cnt_next = cnt;
    if (next_state != state) begin
      cnt_next = '0;
    end else begin
      case (state)
        S_PG_WAIT: cnt_next = pg_s ? cnt + CNT_ONE : '0;
        S_ARMING:  cnt_next = cnt + CNT_ONE;
        S_FAULT: begin
          if (fail_u || !pg_s)     cnt_next = '0;
          else if (cnt != HOLD_MAX) cnt_next = cnt + CNT_ONE;
        end
        default:   cnt_next = '0;
      endcase
    end
  end

  // Output decode from next_state so the registered enables line up with seq_state
  always_comb begin
    pwr_en_d = (next_state == S_ARMING) || (next_state == S_ACTIVE);
    ta_d     = (next_state != S_ACTIVE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= '0;
      pwr_en_reg  <= 1'b0;
      ta_reg      <= 1'b1;
      fault_cause <= '0;
      fault_count <= '0;
    end else begin
      cnt        <= cnt_next;
      pwr_en_reg <= pwr_en_d;
      ta_reg     <= ta_d;
      if (enter_fault) begin
        fault_cause <= {pg_loss_now, fail_vec};
        if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
      end else if (state == S_FAULT) begin
        if (next_state == S_IDLE) fault_cause <= '0;
        else                      fault_cause <= fault_cause | {~pg_s, fail_vec};
      end
    end
  end

  assign laser_pwr_en = pwr_en_reg;
  assign ta_shutdown  = ta_reg | fail_u;
  assign seq_state    = state;

endmodule

// File: tb/tb_laser_interlock_seq.sv
// Bench for laser_interlock_seq: directed sequences with literal checks plus a phase-level
// reference model compared against every output on every clock.
module tb_laser_interlock_seq;

  localparam int PG   = 4;
  localparam int ARM  = 8;
  localparam int HOLD = 16;

  localparam int P_IDLE = 0, P_PGW = 1, P_ARM = 2, P_ACT = 3, P_FLT = 4;

  logic       clk = 1'b0;
  logic       rstn, laser_ready, pwr_good, enable_req, clear_fail;
  logic [3:0] fail_in, fail_mask;
  logic       laser_pwr_en, ta_shutdown;
  logic [2:0] seq_state;
  logic [4:0] fault_cause;
  logic [7:0] fault_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: operating phase plus per-phase elapsed-time counters
  int         m_phase, m_streak, m_age, m_quiet, m_count;
  logic [4:0] m_cause;
  bit         m_pg1, m_pg_s, m_clr_prev;

  laser_interlock_seq #(
    .CNT_W(24), .PG_DEBOUNCE_CYC(PG), .ARM_DELAY_CYC(ARM), .FAULT_HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .rstn(rstn), .laser_ready(laser_ready), .pwr_good(pwr_good),
    .enable_req(enable_req), .clear_fail(clear_fail), .fail_in(fail_in),
    .fail_mask(fail_mask), .laser_pwr_en(laser_pwr_en), .ta_shutdown(ta_shutdown),
    .seq_state(seq_state), .fault_cause(fault_cause), .fault_count(fault_count)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string name);
    int k;
    k = 0;
    while (seq_state !== target && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 32'(seq_state), 32'(target));
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_streak = 0; m_age = 0; m_quiet = 0; m_count = 0;
    m_cause = '0; m_pg1 = 1'b0; m_pg_s = 1'b0; m_clr_prev = 1'b0;
  endtask

  task automatic model_fault(input bit pg_lost, input logic [3:0] fv);
    m_phase = P_FLT;
    m_cause = {pg_lost, fv};
    m_quiet = 0;
    if (m_count < 255) m_count++;
  endtask

  task automatic model_step();
    logic [3:0] fv;
    bit fu, ok, rise, pg_now;
    fv     = fail_in & ~fail_mask;
    fu     = (fv != 4'b0);
    ok     = enable_req && laser_ready;
    rise   = clear_fail && !m_clr_prev;
    pg_now = m_pg_s;
    case (m_phase)
      P_IDLE: begin
        if (fu) model_fault(1'b0, fv);
        else if (ok) begin m_phase = P_PGW; m_streak = 0; end
      end
      P_PGW: begin
        if (fu) model_fault(1'b0, fv);
        else if (!ok) m_phase = P_IDLE;
        else if (!pg_now) m_streak = 0;
        else if (m_streak == PG - 1) begin m_phase = P_ARM; m_age = 0; end
        else m_streak++;
      end
      P_ARM: begin
        if (fu || !pg_now) model_fault(!pg_now, fv);
        else if (!ok) m_phase = P_IDLE;
        else if (m_age == ARM - 1) m_phase = P_ACT;
        else m_age++;
      end
      P_ACT: begin
        if (fu || !pg_now) model_fault(!pg_now, fv);
        else if (!ok) m_phase = P_IDLE;
      end
      default: begin
        if (rise && m_quiet == HOLD && !fu) begin
          m_phase = P_IDLE;
          m_cause = '0;
        end else begin
          m_cause = m_cause | {!pg_now, fv};
          if (fu || !pg_now) m_quiet = 0;
          else if (m_quiet < HOLD) m_quiet++;
        end
      end
    endcase
    m_pg_s     = m_pg1;
    m_pg1      = pwr_good;
    m_clr_prev = clear_fail;
  endtask

  // Compare process: inputs only change on negedges, so they are stable here
  always @(posedge clk) begin
    logic [3:0] fv_now;
    #1;
    if (!rstn) model_reset();
    else       model_step();
    fv_now = fail_in & ~fail_mask;
    check("model_state",  32'(seq_state),    32'(m_phase));
    check("model_pwr_en", 32'(laser_pwr_en), 32'((m_phase == P_ARM) || (m_phase == P_ACT)));
    check("model_ta",     32'(ta_shutdown),  32'((m_phase != P_ACT) || (fv_now != 4'b0)));
    check("model_cause",  32'(fault_cause),  32'(m_cause));
    check("model_count",  32'(fault_count),  32'(m_count));
  end

  initial begin
    rstn = 1'b0; laser_ready = 1'b0; pwr_good = 1'b0; enable_req = 1'b0;
    clear_fail = 1'b0; fail_in = 4'b0; fail_mask = 4'b0;
    tick(3);
    check("rst_state",  32'(seq_state),    32'd0);
    check("rst_pwr_en", 32'(laser_pwr_en), 32'd0);
    check("rst_ta",     32'(ta_shutdown),  32'd1);
    check("rst_cause",  32'(fault_cause),  32'd0);
    check("rst_count",  32'(fault_count),  32'd0);

    // Power-up: two sync cycles, four debounce cycles, eight arming cycles
    rstn = 1'b1; laser_ready = 1'b1; pwr_good = 1'b1; enable_req = 1'b1;
    tick(1); check("pu_pg_wait", 32'(seq_state), 32'd1);
    tick(4); check("pu_still_pg_wait", 32'(seq_state), 32'd1);
    tick(1); check("pu_arming", 32'(seq_state), 32'd2);
    check("pu_arm_pwr_en", 32'(laser_pwr_en), 32'd1);
    check("pu_arm_ta",     32'(ta_shutdown),  32'd1);
    tick(7); check("pu_still_arming", 32'(seq_state), 32'd2);
    tick(1); check("pu_active", 32'(seq_state), 32'd3);
    check("pu_act_ta",     32'(ta_shutdown),  32'd0);
    check("pu_act_pwr_en", 32'(laser_pwr_en), 32'd1);

    // Graceful stop
    enable_req = 1'b0;
    tick(1); check("stop_idle", 32'(seq_state), 32'd0);
    check("stop_no_fault", 32'(fault_count), 32'd0);

    // Debounce restart: one-cycle pwr_good glitch in PG_WAIT
    enable_req = 1'b1;
    tick(2); pwr_good = 1'b0;
    tick(1); pwr_good = 1'b1;
    tick(5); check("deb_restart", 32'(seq_state), 32'd1);
    tick(1); check("deb_arming", 32'(seq_state), 32'd2);
    wait_state(3'd3, 20, "deb_reach_active");

    // Unmasked fail in ACTIVE
    fail_in = 4'b0100;
    #1;
    check("flt_ta_comb",      32'(ta_shutdown),  32'd1);
    check("flt_state_before", 32'(seq_state),    32'd3);
    check("flt_pwr_before",   32'(laser_pwr_en), 32'd1);
    tick(1);
    check("flt_state", 32'(seq_state),    32'd4);
    check("flt_pwr",   32'(laser_pwr_en), 32'd0);
    check("flt_cause", 32'(fault_cause),  32'b00100);
    check("flt_count", 32'(fault_count),  32'd1);
    fail_in = 4'b0;

    // Hold: early clear discarded, clear at full hold accepted
    tick(10); clear_fail = 1'b1;
    tick(1);  check("hold_early_clear", 32'(seq_state), 32'd4);
    clear_fail = 1'b0;
    tick(5);  clear_fail = 1'b1;
    tick(1);
    check("hold_exit",       32'(seq_state),   32'd0);
    check("hold_cause_clr",  32'(fault_cause), 32'd0);
    check("hold_count_kept", 32'(fault_count), 32'd1);
    clear_fail = 1'b0;
    tick(1); check("rerun_pg_wait", 32'(seq_state), 32'd1);

    // Masked fail is ignored
    wait_state(3'd3, 30, "mask_reach_active");
    fail_mask = 4'b1000; fail_in = 4'b1000;
    #1; check("mask_ta", 32'(ta_shutdown), 32'd0);
    tick(2);
    check("mask_state", 32'(seq_state),   32'd3);
    check("mask_count", 32'(fault_count), 32'd1);
    fail_in = 4'b0; fail_mask = 4'b0;

    // Power loss during ARMING
    enable_req = 1'b0;
    tick(1); enable_req = 1'b1;
    wait_state(3'd2, 20, "pgl_reach_arming");
    pwr_good = 1'b0;
    tick(2); check("pgl_sync_delay", 32'(seq_state), 32'd2);
    tick(1);
    check("pgl_state", 32'(seq_state),    32'd4);
    check("pgl_cause", 32'(fault_cause),  32'b10000);
    check("pgl_count", 32'(fault_count),  32'd2);
    check("pgl_pwr",   32'(laser_pwr_en), 32'd0);
    pwr_good = 1'b1; enable_req = 1'b0;
    tick(20); clear_fail = 1'b1;
    tick(1);  check("pgl_cleared", 32'(seq_state), 32'd0);
    clear_fail = 1'b0;
    tick(1);

    // Clear edge coinciding with a new fail: fail wins
    fail_in = 4'b0001;
    tick(1);
    check("cf_fault", 32'(seq_state),   32'd4);
    check("cf_cause", 32'(fault_cause), 32'b00001);
    check("cf_count", 32'(fault_count), 32'd3);
    fail_in = 4'b0;
    tick(17); clear_fail = 1'b1; fail_in = 4'b0001;
    tick(1);  check("cf_fail_wins", 32'(seq_state), 32'd4);
    fail_in = 4'b0; clear_fail = 1'b0;
    tick(17); clear_fail = 1'b1;
    tick(1);  check("cf_exit", 32'(seq_state), 32'd0);
    clear_fail = 1'b0;
    tick(1);

    // fault_count saturation
    for (int i = 0; i < 300; i++) begin
      fail_in = 4'b0010;
      tick(1); fail_in = 4'b0;
      tick(17); clear_fail = 1'b1;
      tick(1);  clear_fail = 1'b0;
      tick(1);
      if (i == 250) check("sat_254", 32'(fault_count), 32'd254);
      if (i == 251) check("sat_255", 32'(fault_count), 32'd255);
    end
    check("sat_final", 32'(fault_count), 32'd255);
    check("sat_idle",  32'(seq_state),   32'd0);

    // Asynchronous reset mid-ARMING
    enable_req = 1'b1;
    wait_state(3'd2, 20, "rst_reach_arming");
    tick(3); rstn = 1'b0;
    #1;
    check("arst_state",  32'(seq_state),    32'd0);
    check("arst_pwr_en", 32'(laser_pwr_en), 32'd0);
    check("arst_ta",     32'(ta_shutdown),  32'd1);
    check("arst_cause",  32'(fault_cause),  32'd0);
    check("arst_count",  32'(fault_count),  32'd0);
    tick(2); rstn = 1'b1; enable_req = 1'b0;
    tick(2); check("arst_after", 32'(seq_state), 32'd0);

    tick(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
